// File: rtl/tdp_ram.sv
// -----------------------------------------------------------------------------
// tdp_ram - true dual-port RAM with per-byte write enables.
//
// Both ports share one clock. Each port reads every cycle and presents the
// word on q_x one cycle later. Reads are read-first: a read of an address
// written on the same edge, by either port, returns the old word. When both
// ports write the same address on one edge, port A owns every lane it enables.
// Port B only lands the lanes that A leaves alone.
//
// Optional feature, selected by macro TDP_RAM_CLEAR_EN:
//   defined   : after every reset, a CLEAR/READY sequencer zeroes the array one
//               word per cycle. This takes DEPTH cycles. While it runs, busy is
//               high, user writes are dropped and q_a/q_b are held at 0.
//   undefined : busy is tied low. The array is usable on the first edge after
//               reset, and its contents start undefined.
//
// Ports:
//   clk     rising-edge clock for all logic
//   reset   synchronous, active-high
//   we_a    [BYTES-1:0]         port A byte write enables
//   addr_a  [ADDRESS_WIDTH-1:0] port A address
//   data_a  [DATA_WIDTH-1:0]    port A write data
//   q_a     [DATA_WIDTH-1:0]    port A registered read data
//   we_b / addr_b / data_b / q_b  same for port B
//   busy    high while the clear sequence runs
// -----------------------------------------------------------------------------
module tdp_ram #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 16384,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH/8-1:0]  we_a,
    input  logic [ADDRESS_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0]    data_a,
    output logic [DATA_WIDTH-1:0]    q_a,
    input  logic [DATA_WIDTH/8-1:0]  we_b,
    input  logic [ADDRESS_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]    data_b,
    output logic [DATA_WIDTH-1:0]    q_b,
    output logic                     busy
);

    localparam int BYTES = DATA_WIDTH / 8;

    // One extra bit, so the comparison also works when DEPTH is a power of 2.
    localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                     clr_we;
    logic [ADDRESS_WIDTH-1:0] cnt_q;

`ifdef TDP_RAM_CLEAR_EN
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The last word is written on the same edge that moves the state to READY.
    // The counter stops there and does not wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == LAST) state_d = READY;
                else               cnt_d   = cnt_q + 1'b1;
            end
            READY: ;
            default: state_d = CLEAR;
        endcase
    end
`else
    assign busy   = 1'b0;
    assign clr_we = 1'b0;
    assign cnt_q  = '0;
`endif

    logic wr_en, a_ok, b_ok;

    assign wr_en = !reset && !busy;
    assign a_ok  = {1'b0, addr_a} < DEPTH_W;
    assign b_ok  = {1'b0, addr_b} < DEPTH_W;

    // Port B lanes are scheduled before port A lanes. Where both ports hit the
    // same lane, A's assignment is the later NBA and therefore wins.
    always_ff @(posedge clk) begin
        if (clr_we && !reset) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (b_ok && we_b[i]) mem[addr_b][8*i +: 8] <= data_b[8*i +: 8];
                if (a_ok && we_a[i]) mem[addr_a][8*i +: 8] <= data_a[8*i +: 8];
            end
        end
    end

    // mem is updated with NBAs, so these reads see the pre-write word.
    always_ff @(posedge clk) begin
        if (reset || busy) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            q_a <= a_ok ? mem[addr_a] : '0;
            q_b <= b_ok ? mem[addr_b] : '0;
        end
    end

endmodule

// File: doc/tdp_ram.md
TDP_RAM -- requirements
Module: tdp_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width in bits, multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 16384, number of words.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL derive local BYTES = DATA_WIDTH/8, the byte-lane count.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL provide the following ports, in this order:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- we_a  in  BYTES  port A byte write enables
- addr_a  in  ADDRESS_WIDTH  port A address
- data_a  in  DATA_WIDTH  port A write data
- q_a  out  DATA_WIDTH  port A registered read data
- we_b  in  BYTES  port B byte write enables
- addr_b  in  ADDRESS_WIDTH  port B address
- data_b  in  DATA_WIDTH  port B write data
- q_b  out  DATA_WIDTH  port B registered read data
- busy  out  1  high while the memory-clear sequence runs

Function
REQ-007 Each port SHALL read every cycle: q_x = mem[addr_x] sampled at edge N, visible after edge N (1-cycle latency).
REQ-008 Byte lane i of port x SHALL be written with data_x[8i+7:8i] when we_x[i]=1, independently per lane.
REQ-009 Same-port read-during-write SHALL be read-first: q_x returns the pre-write word.
REQ-010 Cross-port read of an address written that cycle SHALL also return the pre-write word.
REQ-011 If both ports write the same address in one cycle, then per lane: A wins where we_a[i]=1; B is written where only we_b[i]=1.
REQ-012 Addresses >= DEPTH (non-power-of-2 DEPTH) SHALL be ignored for writes; reads return 0.
REQ-013 Clear FSM (when compiled in) SHALL have states CLEAR and READY.
- CLEAR: writes 0 to mem[cnt], cnt increments by 1 per cycle, busy=1.
- CLEAR -> READY on the cycle cnt = DEPTH-1 is written; cnt is not wrapped.
- READY: normal operation, busy=0; stays until reset.
REQ-014 While busy=1, we_a and we_b SHALL be ignored and q_a, q_b SHALL be held at 0.
REQ-015 First user access SHALL be accepted on the first edge with busy=0; clear SHALL take exactly DEPTH cycles after reset deasserts.

Reset
REQ-016 Reset SHALL be sampled on the clock edge only; asynchronous pulses have no effect.
REQ-017 On reset: q_a=0, q_b=0; with clear compiled in, state=CLEAR, cnt=0, busy=1 from the next cycle.
REQ-018 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-019 Reset asserted in READY SHALL NOT by itself alter memory contents unless clear is compiled in.

Configuration
REQ-020 Macro TDP_RAM_CLEAR_EN SHALL select the clear feature.
- Defined: clear FSM per REQ-013..REQ-015 and REQ-018.
- Undefined: no FSM, busy tied 0, memory usable on the first edge after reset, initial contents undefined (X in simulation), reset clears only q_a and q_b.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- DATA_WIDTH=32, DEPTH=8, TDP_RAM_CLEAR_EN defined; reset 1 cycle -> busy=1 for exactly 8 cycles, then every address reads 0x00000000 on both ports.
- Port A writes 0xDEADBEEF to addr 3 with we_a=4'b0101, prior word 0 -> port B at addr 3 reads 0x00AD00EF.
- Same edge: A writes 0x1111 with we_a=2'b01, B writes 0x2222 with we_b=2'b11, both to addr 5 -> next read 0x2211.
- A writes 0xAAAA to addr 2 (old 0x5555) while B reads addr 2 -> q_b=0x5555 that cycle, 0xAAAA the next.
- Reset asserted at clear cycle 4 of DEPTH=8 -> busy stays high 8 more cycles; a user write during busy is not retained.
- TDP_RAM_CLEAR_EN undefined -> busy=0 always; write/readback 0x1234 at addr 0 works on the first cycle after reset.
